depacketizer_serial: RTL and testbench

- Flit-serial depacketizer for the NoC egress side.
- Accepts one flit per cycle from a router port and reassembles up to NUM_FLITS flits of a packet.
- Strips per-flit control (valid/head/tail/VC) and the head's destination address.
- Presents the concatenated payload on a registered valid/ready output, with VC and error reporting.
- Generalises the combinational 4-flit parallel depacketizer to N flits, early-tail packets, back-pressure buffering and protocol-error recovery.

---
 rtl/depkt_pkg.sv | 31 +++
 rtl/depacketizer_serial_flit_unpack.sv | 38 +++
 rtl/depacketizer_serial.sv | 166 ++++++++++++++++
 tb/tb_depacketizer_serial.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depkt_pkg.sv
// Shared definitions for the serial NoC egress depacketizer.
//   - Control-bit offsets inside a flit, counted down from the flit MSB.
//   - FSM state type.
//   - Width helpers for per-flit payload and the ideal reassembly buffer.
package depkt_pkg;

  localparam int unsigned FLIT_VALID_POS = 0;
  localparam int unsigned FLIT_HEAD_POS  = 1;
  localparam int unsigned FLIT_TAIL_POS  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } depkt_state_e;

  // Payload bits carried by a body flit (valid/head/tail + vc stripped).
  function automatic int unsigned payload_width(input int unsigned width_flit,
                                                input int unsigned vc_width);
    return width_flit - 3 - vc_width;
  endfunction

  // Total payload of a full packet: every flit's payload minus the head's dest.
  function automatic int unsigned data_idl_width(input int unsigned num_flits,
                                                 input int unsigned width_flit,
                                                 input int unsigned vc_width,
                                                 input int unsigned addr_width);
    return num_flits * payload_width(width_flit, vc_width) - addr_width;
  endfunction

endpackage

// File: rtl/depacketizer_serial_flit_unpack.sv
// flit_unpack: combinational field extraction from one flit.
//   flit         in   WIDTH_FLIT  raw flit, layout [valid][head][tail][vc][payload]
//   f_valid      out  1           flit valid bit
//   f_head       out  1           head marker
//   f_tail       out  1           tail marker
//   f_vc         out  VC_ADDRESS_WIDTH  virtual channel id
//   f_dest       out  ADDRESS_WIDTH     destination (meaningful on head flits only)
//   body_payload out  PW          payload of a body flit
//   head_payload out  PW          head payload, left-aligned, dest bits replaced by zeros
module flit_unpack
  import depkt_pkg::*;
#(
  parameter int unsigned WIDTH_FLIT       = 36,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned ADDRESS_WIDTH    = 4,
  localparam int unsigned PW = payload_width(WIDTH_FLIT, VC_ADDRESS_WIDTH)
) (
  input  logic [WIDTH_FLIT-1:0]       flit,
  output logic                        f_valid,
  output logic                        f_head,
  output logic                        f_tail,
  output logic [VC_ADDRESS_WIDTH-1:0] f_vc,
  output logic [ADDRESS_WIDTH-1:0]    f_dest,
  output logic [PW-1:0]               body_payload,
  output logic [PW-1:0]               head_payload
);

  localparam int unsigned HPW = PW - ADDRESS_WIDTH;

  assign f_valid      = flit[WIDTH_FLIT-1-FLIT_VALID_POS];
  assign f_head       = flit[WIDTH_FLIT-1-FLIT_HEAD_POS];
  assign f_tail       = flit[WIDTH_FLIT-1-FLIT_TAIL_POS];
  assign f_vc         = flit[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];
  assign f_dest       = flit[PW-1 -: ADDRESS_WIDTH];
  assign body_payload = flit[PW-1:0];
  assign head_payload = {flit[HPW-1:0], {ADDRESS_WIDTH{1'b0}}};

endmodule

// File: rtl/depacketizer_serial.sv
// depacketizer_serial: flit-serial NoC egress depacketizer.
// Reassembles up to NUM_FLITS flits into one payload word and holds it on a
// valid/ready output until taken.
//   clk        in   1                 clock
//   rst_n      in   1                 synchronous active-low reset
//   flit_in    in   WIDTH_FLIT        flit from router
//   valid_in   in   1                 flit_in valid
//   ready_out  out  1                 flit accepted when valid_in && ready_out
//   data_out   out  WIDTH_DATA        reassembled payload (MSB-aligned)
//   vc_out     out  VC_ADDRESS_WIDTH  VC id of the head flit
//   valid_out  out  1                 packet available
//   ready_in   in   1                 downstream ready
//   err_out    out  1                 one-cycle protocol-error pulse
module depacketizer_serial
  import depkt_pkg::*;
#(
  parameter int unsigned WIDTH_FLIT       = 36,
  parameter int unsigned NUM_FLITS        = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned WIDTH_DATA       = 120
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_FLIT-1:0]       flit_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        err_out
);

  localparam int unsigned PW  = payload_width(WIDTH_FLIT, VC_ADDRESS_WIDTH);
  localparam int unsigned HPW = PW - ADDRESS_WIDTH;
  localparam int unsigned IDL = data_idl_width(NUM_FLITS, WIDTH_FLIT,
                                               VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
  localparam int unsigned CW  = $clog2(NUM_FLITS + 1);

  if (NUM_FLITS < 1 || WIDTH_DATA > IDL) begin : g_bad_cfg
    $error("depacketizer_serial: NUM_FLITS must be >= 1 and WIDTH_DATA <= WIDTH_DATA_IDL");
  end

  logic                        f_valid;
  logic                        f_head;
  logic                        f_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [ADDRESS_WIDTH-1:0]    f_dest;
  logic [PW-1:0]               body_payload;
  logic [PW-1:0]               head_payload;

  flit_unpack #(
    .WIDTH_FLIT       (WIDTH_FLIT),
    .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
    .ADDRESS_WIDTH    (ADDRESS_WIDTH)
  ) u_unpack (
    .flit         (flit_in),
    .f_valid      (f_valid),
    .f_head       (f_head),
    .f_tail       (f_tail),
    .f_vc         (f_vc),
    .f_dest       (f_dest),
    .body_payload (body_payload),
    .head_payload (head_payload)
  );

  depkt_state_e                state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IDL-1:0]              buf_q, buf_d;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
  logic                        err_q, err_d;
  logic                        take;
  logic                        load_head;

  // In HOLD a flit is only accepted together with the output handshake.
  assign ready_out = rst_n && ((state_q != HOLD) || ready_in);
  assign take      = valid_in && ready_out && f_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    vc_d      = vc_q;
    err_d     = 1'b0;
    load_head = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (f_head) load_head = 1'b1;
          else        err_d     = 1'b1;
        end
      end
      COLLECT: begin
        if (take) begin
          if (f_head) begin
            err_d     = 1'b1;
            load_head = 1'b1;
          end else begin
            // Slot k (k >= 1) follows the shorter head slot in the buffer.
            for (int unsigned k = 1; k < NUM_FLITS; k++) begin
              if (cnt_q == CW'(k)) begin
                buf_d[IDL - HPW - (k - 1) * PW - 1 -: PW] = body_payload;
              end
            end
            cnt_d = cnt_q + 1'b1;
            if (f_tail || cnt_d == CW'(NUM_FLITS)) begin
              state_d = HOLD;
              if (!f_tail) err_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (ready_in) state_d = IDLE;
        if (take) begin
          if (f_head) load_head = 1'b1;
          else        err_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Head load overrides the per-state next-state choice so that a restart
    // from COLLECT and a pipelined head in HOLD share one path.
    if (load_head) begin
      buf_d              = '0;
      buf_d[IDL-1 -: HPW] = head_payload[PW-1 -: HPW];
      vc_d               = f_vc;
      cnt_d              = CW'(1);
      if (f_tail || NUM_FLITS == 1) begin
        state_d = HOLD;
        if (!f_tail) err_d = 1'b1;
      end else begin
        state_d = COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      vc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      vc_q    <= vc_d;
      err_q   <= err_d;
    end
  end

  assign valid_out = (state_q == HOLD);
  assign data_out  = buf_q[IDL-1 -: WIDTH_DATA];
  assign vc_out    = vc_q;
  assign err_out   = err_q;

  // Destination and truncated payload LSBs are intentionally discarded.
  logic unused_bits;
  assign unused_bits = ^{f_dest, head_payload, buf_q};

endmodule

// File: tb/tb_depacketizer_serial.sv
module tb_depacketizer_serial;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [35:0]  flit_in;
  logic         valid_in;
  logic         ready_out;
  logic [119:0] data_out;
  logic [0:0]   vc_out;
  logic         valid_out;
  logic         ready_in;
  logic         err_out;

  depacketizer_serial #(
    .WIDTH_FLIT       (36),
    .NUM_FLITS        (4),
    .VC_ADDRESS_WIDTH (1),
    .ADDRESS_WIDTH    (4),
    .WIDTH_DATA       (120)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flit_in   (flit_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .vc_out    (vc_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [35:0] hflit(input logic vc, input logic tail,
                                        input logic [3:0] dest, input logic [27:0] p);
    return {1'b1, 1'b1, tail, vc, dest, p};
  endfunction

  function automatic logic [35:0] bflit(input logic vc, input logic tail, input logic [31:0] p);
    return {1'b1, 1'b0, tail, vc, p};
  endfunction

  typedef struct {
    string        name;
    int           n;
    logic [35:0]  flits [4];
    logic [119:0] data;
    logic         vc;
    logic         err;
  } vec_t;

  vec_t vecs [5];

  // reference model state
  bit           m_coll;
  int           m_n;
  logic [123:0] m_acc;
  logic         m_vc;
  bit           m_out_v;
  logic [119:0] m_out_d;
  logic         m_out_vc;
  bit           m_err;

  task automatic model_finish();
    m_out_v  = 1;
    m_out_d  = m_acc[123:4];
    m_out_vc = m_vc;
    m_coll   = 0;
  endtask

  task automatic model_step(input logic rdy_exp);
    m_err = 0;
    if (m_out_v && ready_in) m_out_v = 0;
    if (valid_in && rdy_exp && flit_in[35]) begin
      if (flit_in[34]) begin
        if (m_coll) m_err = 1;
        m_acc  = {flit_in[27:0], 96'b0};
        m_n    = 1;
        m_vc   = flit_in[32];
        m_coll = 1;
        if (flit_in[33]) model_finish();
      end else if (m_coll) begin
        m_acc = m_acc | ({92'b0, flit_in[31:0]} << (32 * (3 - m_n)));
        m_n++;
        if (flit_in[33] || m_n == 4) begin
          if (!flit_in[33]) m_err = 1;
          model_finish();
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  initial begin
    logic rdy_exp;

    vecs[0].name = "vec_4flit";
    vecs[0].n = 4;
    vecs[0].flits[0] = hflit(1'b1, 1'b0, 4'hA, 28'hABCDEF1);
    vecs[0].flits[1] = bflit(1'b1, 1'b0, 32'h11111111);
    vecs[0].flits[2] = bflit(1'b1, 1'b0, 32'h22222222);
    vecs[0].flits[3] = bflit(1'b1, 1'b1, 32'h33333333);
    vecs[0].data = 120'hABCDEF1_11111111_22222222_3333333;
    vecs[0].vc = 1'b1; vecs[0].err = 1'b0;

    vecs[1].name = "vec_single";
    vecs[1].n = 1;
    vecs[1].flits[0] = hflit(1'b0, 1'b1, 4'hF, 28'hFFFFFFF);
    vecs[1].data = 120'hFFFFFFF << 92;
    vecs[1].vc = 1'b0; vecs[1].err = 1'b0;

    vecs[2].name = "vec_2flit";
    vecs[2].n = 2;
    vecs[2].flits[0] = hflit(1'b0, 1'b0, 4'h3, 28'h1234567);
    vecs[2].flits[1] = bflit(1'b0, 1'b1, 32'hDEADBEEF);
    vecs[2].data = 120'h1234567_DEADBEEF_00000000_0000000;
    vecs[2].vc = 1'b0; vecs[2].err = 1'b0;

    vecs[3].name = "vec_notail";
    vecs[3].n = 4;
    vecs[3].flits[0] = hflit(1'b0, 1'b0, 4'h9, 28'h0000001);
    vecs[3].flits[1] = bflit(1'b0, 1'b0, 32'hAAAAAAAA);
    vecs[3].flits[2] = bflit(1'b0, 1'b0, 32'h55555555);
    vecs[3].flits[3] = bflit(1'b0, 1'b0, 32'hCAFEF00D);
    vecs[3].data = 120'h0000001_AAAAAAAA_55555555_CAFEF00;
    vecs[3].vc = 1'b0; vecs[3].err = 1'b1;

    vecs[4].name = "vec_3flit";
    vecs[4].n = 3;
    vecs[4].flits[0] = hflit(1'b1, 1'b0, 4'h6, 28'h7654321);
    vecs[4].flits[1] = bflit(1'b1, 1'b0, 32'h01234567);
    vecs[4].flits[2] = bflit(1'b1, 1'b1, 32'h89ABCDEF);
    vecs[4].data = 120'h7654321_01234567_89ABCDEF_0000000;
    vecs[4].vc = 1'b1; vecs[4].err = 1'b0;

    // reset
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; flit_in = '0;
    repeat (3) @(negedge clk);
    #1 chk("ready_in_reset", ready_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_err",   err_out,   1'b0);
    chk("rst_data",  data_out,  '0);
    chk("rst_vc",    vc_out,    1'b0);
    chk("rst_ready", ready_out, 1'b1);

    // table vectors
    for (int v = 0; v < 5; v++) begin
      ready_in = 1'b1;
      for (int i = 0; i < vecs[v].n; i++) begin
        @(negedge clk);
        valid_in = 1'b1;
        flit_in  = vecs[v].flits[i];
      end
      @(negedge clk);
      valid_in = 1'b0; flit_in = '0;
      chk({vecs[v].name, "_valid"}, valid_out, 1'b1);
      chk({vecs[v].name, "_data"},  data_out,  vecs[v].data);
      chk({vecs[v].name, "_vc"},    vc_out,    vecs[v].vc);
      chk({vecs[v].name, "_err"},   err_out,   vecs[v].err);
    end

    // back-pressure with a pipelined second head
    @(negedge clk);
    ready_in = 1'b0;
    valid_in = 1'b1; flit_in = hflit(1'b1, 1'b0, 4'h2, 28'hABCDEF1);
    @(negedge clk); flit_in = bflit(1'b1, 1'b0, 32'h11111111);
    @(negedge clk); flit_in = bflit(1'b1, 1'b0, 32'h22222222);
    @(negedge clk); flit_in = bflit(1'b1, 1'b1, 32'h33333333);
    @(negedge clk); flit_in = hflit(1'b0, 1'b0, 4'h5, 28'h0BADC0D);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("stall_ready", ready_out, 1'b0);
      chk("stall_valid", valid_out, 1'b1);
      chk("stall_data",  data_out,  120'hABCDEF1_11111111_22222222_3333333);
    end
    @(negedge clk);
    ready_in = 1'b1;
    #1;
    chk("hs_ready", ready_out, 1'b1);
    chk("hs_valid", valid_out, 1'b1);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h01010101);
    chk("p2_gap1_valid", valid_out, 1'b0);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h20202020);
    chk("p2_gap2_valid", valid_out, 1'b0);
    @(negedge clk); flit_in = bflit(1'b0, 1'b1, 32'h30303030);
    chk("p2_gap3_valid", valid_out, 1'b0);
    @(negedge clk); valid_in = 1'b0;
    chk("p2_valid", valid_out, 1'b1);
    chk("p2_data",  data_out,  120'h0BADC0D_01010101_20202020_3030303);
    chk("p2_vc",    vc_out,    1'b0);
    chk("p2_err",   err_out,   1'b0);

    // body flit while idle
    @(negedge clk); valid_in = 1'b1; flit_in = bflit(1'b1, 1'b1, 32'h77777777);
    @(negedge clk); valid_in = 1'b0;
    chk("idle_body_err",   err_out,   1'b1);
    chk("idle_body_valid", valid_out, 1'b0);
    @(negedge clk);
    chk("idle_body_err_clr", err_out, 1'b0);

    // head arriving mid-packet restarts with the new head
    valid_in = 1'b1; flit_in = hflit(1'b1, 1'b0, 4'h1, 28'h1111111);
    @(negedge clk); flit_in = bflit(1'b1, 1'b0, 32'h44444444);
    @(negedge clk); flit_in = hflit(1'b0, 1'b1, 4'h7, 28'h2222222);
    @(negedge clk); valid_in = 1'b0;
    chk("restart_err",   err_out,   1'b1);
    chk("restart_valid", valid_out, 1'b1);
    chk("restart_data",  data_out,  120'h2222222 << 92);
    chk("restart_vc",    vc_out,    1'b0);

    // 4 flits without tail, then an extra body in the handshake cycle
    @(negedge clk); valid_in = 1'b1; flit_in = hflit(1'b0, 1'b0, 4'hC, 28'h3456789);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h00000001);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h00000002);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h00000003);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h00000009);
    chk("over_valid", valid_out, 1'b1);
    chk("over_err",   err_out,   1'b1);
    chk("over_data",  data_out,  120'h3456789_00000001_00000002_0000000);
    @(negedge clk); valid_in = 1'b0;
    chk("extra_err",   err_out,   1'b1);
    chk("extra_valid", valid_out, 1'b0);
    @(negedge clk);
    chk("extra_err_clr", err_out, 1'b0);

    // reset mid-packet
    valid_in = 1'b1; flit_in = hflit(1'b1, 1'b0, 4'hE, 28'hFEDCBA9);
    @(negedge clk); flit_in = bflit(1'b1, 1'b0, 32'h55555555);
    @(negedge clk); valid_in = 1'b0; rst_n = 1'b0;
    #1 chk("midrst_ready", ready_out, 1'b0);
    @(negedge clk);
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_err",   err_out,   1'b0);
    chk("midrst_data",  data_out,  '0);
    chk("midrst_vc",    vc_out,    1'b0);
    rst_n = 1'b1;
    #1 chk("postrst_ready", ready_out, 1'b1);
    @(negedge clk); valid_in = 1'b1; flit_in = hflit(1'b0, 1'b0, 4'h8, 28'h1357913);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'h24682468);
    @(negedge clk); flit_in = bflit(1'b0, 1'b0, 32'hACE0ACE0);
    @(negedge clk); flit_in = bflit(1'b0, 1'b1, 32'hBDF1BDF1);
    @(negedge clk); valid_in = 1'b0;
    chk("fresh_valid", valid_out, 1'b1);
    chk("fresh_data",  data_out,  120'h1357913_24682468_ACE0ACE0_BDF1BDF);
    chk("fresh_vc",    vc_out,    1'b0);
    chk("fresh_err",   err_out,   1'b0);

    // randomized traffic against the reference model
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_coll = 0; m_n = 0; m_acc = '0; m_vc = 1'b0;
    m_out_v = 0; m_out_d = '0; m_out_vc = 1'b0; m_err = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_valid", valid_out, m_out_v);
      chk("rnd_err",   err_out,   m_err);
      if (m_out_v) begin
        chk("rnd_data", data_out, m_out_d);
        chk("rnd_vc",   vc_out,   m_out_vc);
      end
      ready_in = ($urandom_range(0, 3) != 0);
      valid_in = ($urandom_range(0, 3) != 0);
      flit_in  = {($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 32'($urandom)};
      #1;
      rdy_exp = !m_out_v || ready_in;
      chk("rnd_ready", ready_out, rdy_exp);
      model_step(rdy_exp);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
